axi_gpio_regs: RTL and testbench
================================

Name: axi_gpio_regs

Overview:
- AXI4 single-beat slave register bank directly downstream of the JTAG-to-AXI master.
- Host scripts use it to drive the jc/jd output pins, sample the ja/jb input pins, and check link integrity through ID, scratch and cycle-counter registers.
- Instantiated in the board top level on the PLL clock domain.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, AXI data width (only 32 supported).
BASE_ADDR, 32'h0000_0000, window base; the window is 64 bytes.
ID_VALUE, 32'hA7C0_0001, value returned by the ID register.

Ports:
aclk  in  1  clock
rst  in  1  asynchronous active-high reset
s_axi_awid  in  1  write ID
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wlast  in  1  last beat (must be 1)
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  1  response ID
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  1  read ID
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  1  read ID
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  always 1 when rvalid
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
gpio_in  in  16  {jb, ja}, asynchronous pins
gpio_out  out  16  {jd, jc}, registered

Behaviour:
- Reset: rst is asynchronous and active-high. Asserting it clears all state immediately, including mid-transaction. All valid/ready outputs go to 0; bresp, rresp, rdata, bid, rid and gpio_out go to 0; SCRATCH and CYCLE_CNT go to 0; the write FSM and read FSM go to their idle states.
- Register map (offset = addr[5:2]×4):
  - 0x00 ID: RO, returns ID_VALUE.
  - 0x04 SCRATCH: RW, 32 bits.
  - 0x08 OUT: RW, bits [15:0] drive gpio_out; upper bits read 0.
  - 0x0C IN: RO, 2-flop-synchronized gpio_in; upper bits read 0.
  - 0x10 CYCLE_CNT: RO, free-running and wraps 0xFFFFFFFF→0. Any write clears it to 0; the clear wins over the increment in the same cycle.
- Writes to RO registers: OKAY, no effect.
- Decode:
  - addr[ADDR_WIDTH-1:6] ≠ BASE_ADDR[ADDR_WIDTH-1:6] → DECERR (2'b11).
  - Unmapped offset inside the window → SLVERR (2'b10).
  - addr[1:0] ignored.
- Write FSM:
  - States: W_IDLE, W_GOT_AW, W_GOT_W, W_RESP.
  - awready = 1 in W_IDLE or W_GOT_W. wready = 1 in W_IDLE or W_GOT_AW.
  - AW and W may be accepted in the same cycle (W_IDLE → W_RESP) or in either order.
  - The register update, byte-masked by wstrb, happens on the transition into W_RESP.
  - bvalid rises the next cycle, so minimum latency is 1 cycle from the last handshake to bvalid.
  - bid = captured awid. bvalid is held with stable bid/bresp until bready; then return to W_IDLE.
  - wlast = 0 → SLVERR, no update.
- Read FSM:
  - States: R_IDLE, R_DATA. arready = 1 only in R_IDLE.
  - On AR handshake: rdata, rresp and rid are registered and rvalid = 1 in the next cycle.
  - rvalid and its data are held until rready; then return to R_IDLE. Maximum throughput is one read per 2 cycles.
- Concurrency:
  - Read and write channels are independent.
  - A read and a write committing to the same register in the same cycle: the read returns the old value.
  - CYCLE_CNT reads return the value at the AR handshake cycle.

Optional Feature:
- Macro: AXI_GPIO_REGS_EDGE_CAPTURE_EN.
- Defined:
  - Adds offset 0x14 EDGE, 16 bits, RW1C.
  - A bit sets on any rising edge of the corresponding synchronized gpio_in bit, using a third flop for edge detect.
  - A set event in the same cycle as a W1C of that bit wins, so the bit stays 1.
  - Reset clears EDGE.
- Undefined: offset 0x14 is unmapped (SLVERR), with no extra flops.

Decomposition:
- Package axi_gpio_regs_pkg holds:
  - Register offset localparams.
  - AXI response codes: OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11.
  - Write and read FSM state enums.
- Sub-module gpio_sync_2ff: parameterized-width 2-flop synchronizer on aclk with asynchronous rst, used for gpio_in.

Test Plan:
- Read 0x00 after reset → rdata 0xA7C00001, rresp 00, rlast 1, rvalid exactly 1 cycle after the AR handshake.
- AW and W in the same cycle: write 0xDEADBEEF, wstrb 4'b0101, to 0x04 (SCRATCH = 0) → bresp 00; a read of 0x04 returns 0x00AD00EF.
- Write 0x0000A55A to 0x08 with W 3 cycles before AW and bready low for 5 cycles → bvalid held stable; gpio_out = 0xA55A after the update; bid echoes awid = 1.
- Drive gpio_in = 0x3C81 → a read of 0x0C returns 0x00003C81 no earlier than 2 cycles later. Read 0x20 → SLVERR. Read 0x40 → DECERR.
- Write 0x10, then read 0x10 twice, 10 cycles apart → the second value minus the first = 10. Assert rst while bvalid = 1 → bvalid = 0 immediately and gpio_out = 0.
- With AXI_GPIO_REGS_EDGE_CAPTURE_EN defined: pulse gpio_in[3] high → EDGE reads 0x8; write 0x8 to 0x14 → EDGE reads 0. Without the macro, a read of 0x14 → SLVERR.

Source files
------------

// File: rtl/axi_gpio_regs_pkg.sv
// rtl/axi_gpio_regs_pkg.sv - register offsets, AXI response codes, FSM states and strobe helper
package axi_gpio_regs_pkg;

   localparam logic [5:0] OFF_ID      = 6'h00;
   localparam logic [5:0] OFF_SCRATCH = 6'h04;
   localparam logic [5:0] OFF_OUT     = 6'h08;
   localparam logic [5:0] OFF_IN      = 6'h0C;
   localparam logic [5:0] OFF_CNT     = 6'h10;
   localparam logic [5:0] OFF_EDGE    = 6'h14;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} wr_state_e;
   typedef enum logic {R_IDLE, R_DATA} rd_state_e;

   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

endpackage

// File: rtl/gpio_sync_2ff.sv
// rtl/gpio_sync_2ff.sv - two-flop synchronizer for asynchronous input pins
module gpio_sync_2ff #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/axi_gpio_regs.sv
// rtl/axi_gpio_regs.sv - AXI4 single-beat GPIO/ID/scratch/counter register bank
// Define AXI_GPIO_REGS_EDGE_CAPTURE_EN to add the RW1C rising-edge capture register at 0x14.
module axi_gpio_regs
   import axi_gpio_regs_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter logic [31:0]           ID_VALUE   = 32'hA7C0_0001
) (
   input  logic                  aclk,
   input  logic                  rst,
   input  logic                  s_axi_awid,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [DATA_WIDTH-1:0] s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   input  logic                  s_axi_wlast,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic                  s_axi_bid,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic                  s_axi_arid,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic                  s_axi_rid,
   output logic [DATA_WIDTH-1:0] s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rlast,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   input  logic [15:0]           gpio_in,
   output logic [15:0]           gpio_out
);

   logic [15:0] in_sync;
   logic [31:0] scratch_q, scratch_d;
   logic [31:0] cnt_q, cnt_d;
   logic [15:0] out_q, out_d;
`ifdef AXI_GPIO_REGS_EDGE_CAPTURE_EN
   logic [15:0] in_dly_q, edge_q, edge_d, edge_clr;
`endif

   // Byte-lane address bits play no part in decode.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   gpio_sync_2ff #(.WIDTH(16)) u_gpio_sync (
      .clk_i (aclk),
      .rst_i (rst),
      .d_i   (gpio_in),
      .q_o   (in_sync)
   );

   function automatic logic reg_mapped(input logic [5:0] off);
      case (off)
         OFF_ID, OFF_SCRATCH, OFF_OUT, OFF_IN, OFF_CNT: reg_mapped = 1'b1;
`ifdef AXI_GPIO_REGS_EDGE_CAPTURE_EN
         OFF_EDGE: reg_mapped = 1'b1;
`endif
         default: reg_mapped = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] decode(input logic [ADDR_WIDTH-1:2] a);
      if (a[ADDR_WIDTH-1:6] != BASE_ADDR[ADDR_WIDTH-1:6]) return RESP_DECERR;
      if (!reg_mapped({a[5:2], 2'b00})) return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

   // ---------------- write channel ----------------
   wr_state_e             wr_state_q;
   logic                  awready_q, wready_q, bvalid_q, bid_q;
   logic [1:0]            bresp_q;
   logic [ADDR_WIDTH-1:2] aw_addr_q;
   logic                  aw_id_q;
   logic [31:0]           w_data_q;
   logic [3:0]            w_strb_q;
   logic                  w_last_q;

   logic                  aw_hs, w_hs, wr_commit, wr_en, wr_id, wr_last;
   logic [ADDR_WIDTH-1:2] wr_addr;
   logic [31:0]           wr_data, wr_mask;
   logic [3:0]            wr_strb;
   logic [1:0]            wr_resp;
   logic [5:0]            wr_off;

   assign aw_hs = s_axi_awvalid & awready_q;
   assign w_hs  = s_axi_wvalid & wready_q;

   // Whichever half arrived earlier comes from its capture register, the other from the bus.
   always_comb begin
      wr_addr   = (wr_state_q == W_GOT_AW) ? aw_addr_q : s_axi_awaddr[ADDR_WIDTH-1:2];
      wr_id     = (wr_state_q == W_GOT_AW) ? aw_id_q : s_axi_awid;
      wr_data   = (wr_state_q == W_GOT_W) ? w_data_q : s_axi_wdata;
      wr_strb   = (wr_state_q == W_GOT_W) ? w_strb_q : s_axi_wstrb;
      wr_last   = (wr_state_q == W_GOT_W) ? w_last_q : s_axi_wlast;
      wr_commit = ((wr_state_q == W_IDLE) && aw_hs && w_hs) ||
                  ((wr_state_q == W_GOT_AW) && w_hs) ||
                  ((wr_state_q == W_GOT_W) && aw_hs);
      wr_resp   = decode(wr_addr);
      if (wr_resp == RESP_OKAY && !wr_last) wr_resp = RESP_SLVERR;
      wr_en     = wr_commit && (wr_resp == RESP_OKAY);
      wr_off    = {wr_addr[5:2], 2'b00};
      wr_mask   = strb_mask(wr_strb);
   end

   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         wr_state_q <= W_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         bid_q      <= 1'b0;
         aw_addr_q  <= '0;
         aw_id_q    <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         w_last_q   <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_addr_q <= s_axi_awaddr[ADDR_WIDTH-1:2];
            aw_id_q   <= s_axi_awid;
         end
         if (w_hs) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
            w_last_q <= s_axi_wlast;
         end
         if (wr_commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_resp;
            bid_q    <= wr_id;
         end
         case (wr_state_q)
            W_IDLE: begin
               if (aw_hs && w_hs) begin
                  wr_state_q <= W_RESP;
                  awready_q  <= 1'b0;
                  wready_q   <= 1'b0;
               end else if (aw_hs) begin
                  wr_state_q <= W_GOT_AW;
                  awready_q  <= 1'b0;
                  wready_q   <= 1'b1;
               end else if (w_hs) begin
                  wr_state_q <= W_GOT_W;
                  awready_q  <= 1'b1;
                  wready_q   <= 1'b0;
               end else begin
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            W_GOT_AW: if (w_hs) begin
               wr_state_q <= W_RESP;
               wready_q   <= 1'b0;
            end
            W_GOT_W: if (aw_hs) begin
               wr_state_q <= W_RESP;
               awready_q  <= 1'b0;
            end
            W_RESP: if (s_axi_bready) begin
               wr_state_q <= W_IDLE;
               bvalid_q   <= 1'b0;
               awready_q  <= 1'b1;
               wready_q   <= 1'b1;
            end
            default: wr_state_q <= W_IDLE;
         endcase
      end
   end

   // ---------------- register file ----------------
   always_comb begin
      scratch_d = scratch_q;
      out_d     = out_q;
      cnt_d     = cnt_q + 32'd1;
      if (wr_en) begin
         case (wr_off)
            OFF_SCRATCH: scratch_d = (scratch_q & ~wr_mask) | (wr_data & wr_mask);
            OFF_OUT:     out_d = (out_q & ~wr_mask[15:0]) | (wr_data[15:0] & wr_mask[15:0]);
            OFF_CNT:     cnt_d = '0;
            default: ;
         endcase
      end
   end

`ifdef AXI_GPIO_REGS_EDGE_CAPTURE_EN
   // A rising edge in the same cycle as its W1C keeps the bit set.
   always_comb begin
      edge_clr = '0;
      if (wr_en && wr_off == OFF_EDGE) edge_clr = wr_data[15:0] & wr_mask[15:0];
      edge_d = (edge_q & ~edge_clr) | (in_sync & ~in_dly_q);
   end
`endif

   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         scratch_q <= '0;
         out_q     <= '0;
         cnt_q     <= '0;
`ifdef AXI_GPIO_REGS_EDGE_CAPTURE_EN
         in_dly_q  <= '0;
         edge_q    <= '0;
`endif
      end else begin
         scratch_q <= scratch_d;
         out_q     <= out_d;
         cnt_q     <= cnt_d;
`ifdef AXI_GPIO_REGS_EDGE_CAPTURE_EN
         in_dly_q  <= in_sync;
         edge_q    <= edge_d;
`endif
      end
   end

   // ---------------- read channel ----------------
   rd_state_e   rd_state_q;
   logic        arready_q, rvalid_q, rid_q;
   logic [1:0]  rresp_q, ar_resp;
   logic [31:0] rdata_q, rd_mux;
   logic [5:0]  ar_off;
   logic        ar_hs;

   assign ar_hs   = s_axi_arvalid & arready_q;
   assign ar_resp = decode(s_axi_araddr[ADDR_WIDTH-1:2]);
   assign ar_off  = {s_axi_araddr[5:2], 2'b00};

   always_comb begin
      rd_mux = '0;
      case (ar_off)
         OFF_ID:      rd_mux = ID_VALUE;
         OFF_SCRATCH: rd_mux = scratch_q;
         OFF_OUT:     rd_mux = {16'h0, out_q};
         OFF_IN:      rd_mux = {16'h0, in_sync};
         OFF_CNT:     rd_mux = cnt_q;
`ifdef AXI_GPIO_REGS_EDGE_CAPTURE_EN
         OFF_EDGE:    rd_mux = {16'h0, edge_q};
`endif
         default: ;
      endcase
   end

   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         rd_state_q <= R_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rid_q      <= 1'b0;
         rresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
      end else begin
         case (rd_state_q)
            R_IDLE: begin
               if (ar_hs) begin
                  rd_state_q <= R_DATA;
                  arready_q  <= 1'b0;
                  rvalid_q   <= 1'b1;
                  rid_q      <= s_axi_arid;
                  rresp_q    <= ar_resp;
                  rdata_q    <= (ar_resp == RESP_OKAY) ? rd_mux : '0;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: if (s_axi_rready) begin
               rd_state_q <= R_IDLE;
               rvalid_q   <= 1'b0;
               arready_q  <= 1'b1;
            end
            default: rd_state_q <= R_IDLE;
         endcase
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_bid     = bid_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rid     = rid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rlast   = rvalid_q;
   assign gpio_out      = out_q;

endmodule

// File: tb/tb_axi_gpio_regs.sv
// tb/tb_axi_gpio_regs.sv - table-driven and directed checks for axi_gpio_regs
module tb_axi_gpio_regs;

   logic        aclk, rst;
   logic        s_axi_awid, s_axi_awvalid, s_axi_awready;
   logic [31:0] s_axi_awaddr;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
   logic        s_axi_bid, s_axi_bvalid, s_axi_bready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_arid, s_axi_arvalid, s_axi_arready;
   logic [31:0] s_axi_araddr;
   logic        s_axi_rid, s_axi_rlast, s_axi_rvalid, s_axi_rready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic [15:0] gpio_in, gpio_out;

   axi_gpio_regs dut (
      .aclk(aclk), .rst(rst),
      .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid),
      .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready),
      .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready),
      .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .gpio_in(gpio_in), .gpio_out(gpio_out)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      bit          last;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

`ifdef AXI_GPIO_REGS_EDGE_CAPTURE_EN
   localparam logic [1:0] EDGE_RESP = 2'b00;
`else
   localparam logic [1:0] EDGE_RESP = 2'b10;
`endif

   vec_t        vecs[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] rd, v1, v2;
   logic [1:0]  rsp;
   logic        idv, lastv;
   int          lat, n;
   bit          stable;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic id, input logic last,
                            output logic [1:0] resp, output logic bid_o, output int wlat);
      bit aw_done, w_done, aw_fire, w_fire;
      int k;
      s_axi_awaddr = addr; s_axi_awid = id; s_axi_awvalid = 1'b1;
      s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
      aw_done = 0; w_done = 0; k = 0;
      while (!(aw_done && w_done) && k < 50) begin
         aw_fire = s_axi_awvalid && s_axi_awready;
         w_fire  = s_axi_wvalid && s_axi_wready;
         tick();
         k++;
         if (aw_fire) begin s_axi_awvalid = 1'b0; aw_done = 1; end
         if (w_fire)  begin s_axi_wvalid = 1'b0;  w_done = 1;  end
      end
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      check("wr_accepted", 32'({aw_done, w_done}), 32'h3);
      wlat = 0;
      while (!s_axi_bvalid && wlat < 50) begin tick(); wlat++; end
      check("bvalid_seen", 32'(s_axi_bvalid), 32'h1);
      resp = s_axi_bresp; bid_o = s_axi_bid;
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic id,
                           output logic [31:0] data, output logic [1:0] resp,
                           output logic rid_o, output logic last, output int rlat);
      int k;
      s_axi_araddr = addr; s_axi_arid = id; s_axi_arvalid = 1'b1;
      k = 0;
      while (!s_axi_arready && k < 50) begin tick(); k++; end
      tick();
      s_axi_arvalid = 1'b0;
      rlat = 0;
      while (!s_axi_rvalid && rlat < 50) begin tick(); rlat++; end
      check("rvalid_seen", 32'(s_axi_rvalid), 32'h1);
      data = s_axi_rdata; resp = s_axi_rresp; rid_o = s_axi_rid; last = s_axi_rlast;
      s_axi_rready = 1'b1;
      tick();
      s_axi_rready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      s_axi_awid = 0; s_axi_awaddr = '0; s_axi_awvalid = 0;
      s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0; s_axi_wvalid = 0;
      s_axi_bready = 0; s_axi_arid = 0; s_axi_araddr = '0; s_axi_arvalid = 0;
      s_axi_rready = 0; gpio_in = '0;

      vecs.push_back('{1'b0, 32'h00, 32'h0,        4'h0, 1'b1, 2'b00, 32'hA7C00001});
      vecs.push_back('{1'b1, 32'h04, 32'h12345678, 4'hF, 1'b1, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 32'h04, 32'h0,        4'h0, 1'b1, 2'b00, 32'h12345678});
      vecs.push_back('{1'b1, 32'h04, 32'hAABBCCDD, 4'h8, 1'b1, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 32'h04, 32'h0,        4'h0, 1'b1, 2'b00, 32'hAA345678});
      vecs.push_back('{1'b1, 32'h08, 32'hFFFF1234, 4'hF, 1'b1, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 32'h08, 32'h0,        4'h0, 1'b1, 2'b00, 32'h00001234});
      vecs.push_back('{1'b1, 32'h08, 32'h00009900, 4'h2, 1'b1, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 32'h08, 32'h0,        4'h0, 1'b1, 2'b00, 32'h00009934});
      vecs.push_back('{1'b1, 32'h00, 32'hFFFFFFFF, 4'hF, 1'b1, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 32'h00, 32'h0,        4'h0, 1'b1, 2'b00, 32'hA7C00001});
      vecs.push_back('{1'b1, 32'h0C, 32'h0000FFFF, 4'hF, 1'b1, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 32'h0C, 32'h0,        4'h0, 1'b1, 2'b00, 32'h00000000});
      vecs.push_back('{1'b0, 32'h20, 32'h0,        4'h0, 1'b1, 2'b10, 32'h0});
      vecs.push_back('{1'b1, 32'h20, 32'h1,        4'hF, 1'b1, 2'b10, 32'h0});
      vecs.push_back('{1'b0, 32'h40, 32'h0,        4'h0, 1'b1, 2'b11, 32'h0});
      vecs.push_back('{1'b1, 32'h44, 32'h55555555, 4'hF, 1'b1, 2'b11, 32'h0});
      vecs.push_back('{1'b1, 32'h3C, 32'h1,        4'hF, 1'b1, 2'b10, 32'h0});
      vecs.push_back('{1'b0, 32'h07, 32'h0,        4'h0, 1'b1, 2'b00, 32'hAA345678});
      vecs.push_back('{1'b0, 32'h14, 32'h0,        4'h0, 1'b1, EDGE_RESP, 32'h0});
      vecs.push_back('{1'b1, 32'h04, 32'h11111111, 4'hF, 1'b0, 2'b10, 32'h0});
      vecs.push_back('{1'b0, 32'h04, 32'h0,        4'h0, 1'b1, 2'b00, 32'hAA345678});

      tick(); tick();
      check("reset_handshake_outputs",
            32'({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}), 32'h0);
      check("reset_gpio_out", 32'(gpio_out), 32'h0);
      check("reset_rdata_resp", 32'({s_axi_rdata[15:0], s_axi_rresp, s_axi_bresp}), 32'h0);
      rst = 1'b0;
      tick(); tick();

      // ID read: data, response, rlast and single-cycle latency
      axi_read(32'h00, 1'b1, rd, rsp, idv, lastv, lat);
      check("id_rdata", rd, 32'hA7C00001);
      check("id_rresp", 32'(rsp), 32'h0);
      check("id_rlast", 32'(lastv), 32'h1);
      check("id_rid", 32'(idv), 32'h1);
      check("id_rvalid_latency", 32'(lat), 32'h0);

      // AW and W together, partial strobes onto a cleared SCRATCH
      axi_write(32'h04, 32'hDEADBEEF, 4'b0101, 1'b0, 1'b1, rsp, idv, lat);
      check("same_cycle_bresp", 32'(rsp), 32'h0);
      check("same_cycle_bvalid_latency", 32'(lat), 32'h0);
      axi_read(32'h04, 1'b0, rd, rsp, idv, lastv, lat);
      check("same_cycle_scratch", rd, 32'h00AD00EF);

      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 1'b0, vecs[i].last, rsp, idv, lat);
            check($sformatf("vec%0d_bresp", i), 32'(rsp), 32'(vecs[i].resp));
         end else begin
            axi_read(vecs[i].addr, 1'b0, rd, rsp, idv, lastv, lat);
            check($sformatf("vec%0d_rresp", i), 32'(rsp), 32'(vecs[i].resp));
            if (vecs[i].resp == 2'b00) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
         end
      end

      // W three cycles ahead of AW, then bready held low for five cycles
      s_axi_wdata = 32'h0000A55A; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 20) begin tick(); n++; end
      tick();
      s_axi_wvalid = 1'b0;
      check("w_first_awready", 32'({s_axi_awready, s_axi_wready}), 32'h2);
      tick(); tick();
      s_axi_awaddr = 32'h08; s_axi_awid = 1'b1; s_axi_awvalid = 1'b1;
      check("w_first_bvalid_low", 32'(s_axi_bvalid), 32'h0);
      tick();
      s_axi_awvalid = 1'b0;
      check("w_first_bvalid", 32'(s_axi_bvalid), 32'h1);
      check("w_first_gpio_out", 32'(gpio_out), 32'h0000A55A);
      stable = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (s_axi_bvalid !== 1'b1 || s_axi_bid !== 1'b1 || s_axi_bresp !== 2'b00) stable = 0;
      end
      check("w_first_b_held", 32'(stable), 32'h1);
      check("w_first_bid", 32'(s_axi_bid), 32'h1);
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
      check("w_first_bvalid_drop", 32'(s_axi_bvalid), 32'h0);

      // Input synchronizer: not visible one cycle after the pin change
      gpio_in = 16'h3C81;
      tick();
      axi_read(32'h0C, 1'b0, rd, rsp, idv, lastv, lat);
      check("in_sync_early", rd, 32'h0);
      axi_read(32'h0C, 1'b0, rd, rsp, idv, lastv, lat);
      check("in_sync_value", rd, 32'h00003C81);
      axi_read(32'h20, 1'b0, rd, rsp, idv, lastv, lat);
      check("unmapped_slverr", 32'(rsp), 32'h2);
      axi_read(32'h40, 1'b0, rd, rsp, idv, lastv, lat);
      check("outside_decerr", 32'(rsp), 32'h3);
      gpio_in = 16'h0000;
      tick(); tick(); tick();

      // CYCLE_CNT: clear on write, then 10-cycle delta between AR handshakes
      axi_write(32'h10, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, rsp, idv, lat);
      check("cnt_write_bresp", 32'(rsp), 32'h0);
      axi_read(32'h10, 1'b0, v1, rsp, idv, lastv, lat);
      check("cnt_after_clear", v1, 32'h1);
      for (int i = 0; i < 8; i++) tick();
      axi_read(32'h10, 1'b0, v2, rsp, idv, lastv, lat);
      check("cnt_delta", v2 - v1, 32'd10);

      // Asynchronous reset while a write response is pending
      s_axi_awaddr = 32'h08; s_axi_awid = 1'b0; s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'h00005A5A; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      check("rst_pre_bvalid", 32'(s_axi_bvalid), 32'h1);
      check("rst_pre_gpio_out", 32'(gpio_out), 32'h00005A5A);
      rst = 1'b1;
      #1;
      check("rst_async_bvalid", 32'(s_axi_bvalid), 32'h0);
      check("rst_async_gpio_out", 32'(gpio_out), 32'h0);
      tick(); tick();
      rst = 1'b0;
      tick(); tick();
      axi_read(32'h04, 1'b0, rd, rsp, idv, lastv, lat);
      check("rst_scratch_cleared", rd, 32'h0);

`ifdef AXI_GPIO_REGS_EDGE_CAPTURE_EN
      gpio_in = 16'h0008;
      for (int i = 0; i < 4; i++) tick();
      gpio_in = 16'h0000;
      for (int i = 0; i < 4; i++) tick();
      axi_read(32'h14, 1'b0, rd, rsp, idv, lastv, lat);
      check("edge_captured", rd, 32'h8);
      axi_write(32'h14, 32'h8, 4'hF, 1'b0, 1'b1, rsp, idv, lat);
      check("edge_w1c_bresp", 32'(rsp), 32'h0);
      axi_read(32'h14, 1'b0, rd, rsp, idv, lastv, lat);
      check("edge_cleared", rd, 32'h0);
`else
      axi_read(32'h14, 1'b0, rd, rsp, idv, lastv, lat);
      check("edge_absent_slverr", 32'(rsp), 32'h2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
